// File: rtl/swa_pkg.sv
// Shared types and constants for the sliding window adder and its ring buffer.
package swa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } swa_state_e;

    // A window of at most 2**log2_depth samples of dw bits cannot carry past this width.
    function automatic int swa_sum_width(input int dw, input int log2_depth);
        return dw + log2_depth;
    endfunction

endpackage

// File: rtl/swa_ring_buffer.sv
// Sample history for the sliding window adder: one write port and one
// combinational read port, so an entry can be read in the cycle it is overwritten.
module swa_ring_buffer
    import swa_pkg::*;
#(
    parameter int DW         = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [LOG2_DEPTH-1:0] waddr_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [LOG2_DEPTH-1:0] raddr_i,
    output logic [DW-1:0]         rdata_o
);

    localparam int MAXW = 1 << LOG2_DEPTH;

    // Contents are never reset; the accumulator only reads entries written since the last restart.
    logic [DW-1:0] mem [MAXW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sliding_window_adder.sv
// Running sum of the last min(count, window) accepted samples, one-cycle latency.
// Optional synchronous restart input clr when SLIDING_WINDOW_ADDER_CLEAR_EN is defined.
module sliding_window_adder
    import swa_pkg::*;
#(
    parameter int DW         = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
    input  logic                                        clr,
`endif
    input  logic                                        in_valid,
    input  logic [DW-1:0]                               inp,
    input  logic [LOG2_DEPTH:0]                         win_len,
    output logic                                        out_valid,
    output logic [swa_sum_width(DW, LOG2_DEPTH)-1:0]    sum_out,
    output logic                                        out_full
);

    localparam int MAXW = 1 << LOG2_DEPTH;
    localparam int SW   = swa_sum_width(DW, LOG2_DEPTH);
    localparam int CW   = LOG2_DEPTH + 1;

    localparam logic [CW-1:0] WIN_ONE = CW'(1);
    localparam logic [CW-1:0] WIN_MAX = CW'(MAXW);

    swa_state_e            state_q, state_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         win_q, win_d;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  valid_q, valid_d;
    logic                  full_q, full_d;

    logic [CW-1:0]         eff_win;
    logic                  clr_s;
    logic                  restart;
    logic                  accept;
    logic                  ring_we;
    logic [LOG2_DEPTH-1:0] rd_addr;
    logic [DW-1:0]         oldest;

    swa_state_e            cur_state;
    logic [SW-1:0]         cur_sum;
    logic [CW-1:0]         cur_cnt;

`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
    assign clr_s = clr;
`else
    assign clr_s = 1'b0;
`endif

    always_comb begin
        eff_win = win_len;
        if (win_len == '0) begin
            eff_win = WIN_ONE;
        end else if (win_len > WIN_MAX) begin
            eff_win = WIN_MAX;
        end
    end

    assign restart = (eff_win != win_q) || clr_s;
    assign accept  = in_valid && !clr_s;

    // At window=MAXW the low bits of win_q are zero, so the read hits the slot being written.
    assign rd_addr = wr_ptr_q - win_q[LOG2_DEPTH-1:0];

    swa_ring_buffer #(
        .DW         (DW),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (clk),
        .we_i    (ring_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (inp),
        .raddr_i (rd_addr),
        .rdata_o (oldest)
    );

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        wr_ptr_d  = wr_ptr_q;
        full_d    = full_q;
        valid_d   = 1'b0;
        ring_we   = 1'b0;
        cur_state = state_q;
        cur_sum   = sum_q;
        cur_cnt   = cnt_q;

        if (restart) begin
            win_d     = eff_win;
            cur_state = IDLE;
            cur_sum   = '0;
            cur_cnt   = '0;
            state_d   = IDLE;
            sum_d     = '0;
            cnt_d     = '0;
            full_d    = 1'b0;
        end

        if (accept) begin
            ring_we  = 1'b1;
            wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
            valid_d  = 1'b1;
            case (cur_state)
                RUN: begin
                    sum_d   = cur_sum + SW'(inp) - SW'(oldest);
                    state_d = RUN;
                end
                default: begin
                    sum_d   = cur_sum + SW'(inp);
                    cnt_d   = cur_cnt + CW'(1);
                    state_d = (cnt_d == win_d) ? RUN : FILL;
                end
            endcase
            full_d = (state_d == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            cnt_q    <= '0;
            win_q    <= WIN_ONE;
            wr_ptr_q <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign out_valid = valid_q;
    assign sum_out   = sum_q;
    assign out_full  = full_q;

endmodule

// File: tb/tb_sliding_window_adder.sv
// Directed and random stimulus against a queue-based model of the windowed sum.
module tb_sliding_window_adder;

    localparam int DW   = 8;
    localparam int L2D  = 2;
    localparam int MAXW = 1 << L2D;
    localparam int SW   = DW + L2D;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [DW-1:0]   inp;
    logic [L2D:0]    win_len;
    logic            out_valid;
    logic [SW-1:0]   sum_out;
    logic            out_full;
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
    logic            clr;
`endif

    int checks   = 0;
    int failures = 0;

    int hist[$];
    int m_win;
    int m_sum;
    bit m_full;
    bit m_valid;

    always #5 clk = ~clk;

    sliding_window_adder #(
        .DW         (DW),
        .LOG2_DEPTH (L2D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
        .clr       (clr),
`endif
        .in_valid  (in_valid),
        .inp       (inp),
        .win_len   (win_len),
        .out_valid (out_valid),
        .sum_out   (sum_out),
        .out_full  (out_full)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_window(input int wl);
        if (wl == 0) return 1;
        if (wl > MAXW) return MAXW;
        return wl;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_win   = 1;
        m_sum   = 0;
        m_full  = 0;
        m_valid = 0;
    endtask

    task automatic model_step(input bit v, input int d, input int wl, input bit c);
        int e;
        int n;
        e = eff_window(wl);
        if (e != m_win || c) begin
            hist.delete();
            m_win  = e;
            m_sum  = 0;
            m_full = 0;
        end
        m_valid = v && !c;
        if (m_valid) begin
            hist.push_back(d);
            if (hist.size() > MAXW) void'(hist.pop_front());
            n = (hist.size() < m_win) ? hist.size() : m_win;
            m_sum = 0;
            for (int k = 0; k < n; k++) m_sum += hist[hist.size() - 1 - k];
            m_full = (hist.size() >= m_win);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, int'(out_valid), int'(m_valid));
        chk({tag, ".sum"},   int'(sum_out),   m_sum);
        chk({tag, ".full"},  int'(out_full),  int'(m_full));
        $display("step %-8s v=%0b d=%0d wl=%0d -> out_valid=%0b sum=%0d full=%0b",
                 tag, in_valid, inp, win_len, out_valid, sum_out, out_full);
    endtask

    task automatic step(input string tag, input bit v, input int d, input int wl, input bit c = 1'b0);
        @(negedge clk);
        in_valid = v;
        inp      = DW'(d);
        win_len  = (L2D+1)'(wl);
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
        clr      = c;
`endif
        model_step(v, d, wl, c);
        @(posedge clk);
        #1;
        check_outputs(tag);
        in_valid = 1'b0;
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
        clr      = 1'b0;
`endif
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".sum"},   int'(sum_out),   0);
        chk({tag, ".full"},  int'(out_full),  0);
        $display("reset %-8s out_valid=%0b sum=%0d full=%0b", tag, out_valid, sum_out, out_full);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        inp      = '0;
        win_len  = 3'd1;
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
        clr      = 1'b0;
`endif
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.sum",   int'(sum_out),   0);
        chk("rst.full",  int'(out_full),  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // window 3, samples 1..5 -> 1,3,6,9,12
        for (int i = 1; i <= 5; i++) step("w3", 1'b1, i, 3);
        chk("w3.final", int'(sum_out), 12);

        // full window of 255s; wr_ptr wraps three times
        for (int i = 0; i < 12; i++) step("sat", 1'b1, 255, 4);
        chk("sat.final", int'(sum_out), 1020);

        // gaps at window 2
        step("gap", 1'b1, 1, 2);
        step("gap", 1'b0, 0, 2);
        step("gap", 1'b1, 2, 2);
        step("gap", 1'b0, 0, 2);
        step("gap", 1'b0, 0, 2);
        step("gap", 1'b1, 3, 2);
        chk("gap.final", int'(sum_out), 5);

        // window change 3 -> 2 in RUN together with a sample
        for (int i = 1; i <= 4; i++) step("pre", 1'b1, i * 10, 3);
        step("chg", 1'b1, 7, 2);
        chk("chg.sum", int'(sum_out), 7);
        step("chg", 1'b1, 1, 2);
        chk("chg.next", int'(sum_out), 8);

        // window change without a sample restarts and clears
        step("chg0", 1'b0, 0, 4);

        // clamping of out-of-range window requests
        for (int i = 0; i < 3; i++) step("wl0", 1'b1, 20 + i, 0);
        for (int i = 0; i < 6; i++) step("wl7", 1'b1, 100 + i, 7);

        // asynchronous reset mid-RUN
        for (int i = 0; i < 4; i++) step("run", 1'b1, 50 + i, 2);
        async_reset("midrun");
        step("post", 1'b1, 9, 2);
        chk("post.sum", int'(sum_out), 9);

`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
        for (int i = 0; i < 3; i++) step("preclr", 1'b1, 5, 2);
        step("clr", 1'b1, 77, 2, 1'b1);
        chk("clr.sum", int'(sum_out), 0);
        step("clr", 1'b1, 4, 2);
        chk("clr.next", int'(sum_out), 4);
`endif

        // random traffic with occasional window changes and resets
        begin
            int wl;
            wl = 3;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 29) == 0) wl = $urandom_range(0, 7);
                if ($urandom_range(0, 149) == 0) async_reset("rnd");
`ifdef SLIDING_WINDOW_ADDER_CLEAR_EN
                step("rnd", ($urandom_range(0, 9) < 7), $urandom_range(0, 255), wl,
                     ($urandom_range(0, 39) == 0));
`else
                step("rnd", ($urandom_range(0, 9) < 7), $urandom_range(0, 255), wl);
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
